axi4_burst_addr_gen: RTL
========================

# axi4_burst_addr_gen

Synthesisable per-beat address generator for AXI4 write and read bursts. It sits directly downstream of the address-channel capture. It accepts one burst command (address, length, size, burst type) encoded with the package `awburst_e`/`arburst_e` and `awsize_e`/`arsize_e` codings. It then emits one beat address per cycle with index, last and error flags to the slave data/memory stage, which uses `beat_err` to return SLVERR.

## Interface
- `ADDRESS_WIDTH`, 32, address bus width.
- `DATA_WIDTH`, 32, data bus width in bits. Maximum legal size is log2(DATA_WIDTH/8).
- `aclk` in 1: clock, rising edge.
- `areset` in 1: reset; one clock, synchronous, active-high.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_addr` in ADDRESS_WIDTH: burst start address.
- `cmd_len` in 8: beats minus one.
- `cmd_size` in 3: bytes per beat = 2^cmd_size.
- `cmd_burst` in 2: 00 FIXED, 01 INCR, 10 WRAP, 11 RESERVED.
- `beat_valid` out 1: beat address valid.
- `beat_ready` in 1: beat consumed when both are high.
- `beat_addr` out ADDRESS_WIDTH: address of current beat.
- `beat_idx` out 8: beat number, 0..len.
- `beat_last` out 1: current beat is beat len.
- `beat_err` out 1: burst is illegal; constant over the whole burst.
- `busy` out 1: burst in progress.

## Operation
- FSM has two states, IDLE and BURST. Reset state is IDLE.
- `cmd_ready` = IDLE && !areset.
- IDLE -> BURST on command handshake. Latch the command, compute bytes = 2^size, and compute the error flag.
- BURST -> IDLE on handshake of the last beat.
- Beat 0 address is `cmd_addr` exactly, unaligned allowed.
- FIXED: every beat uses `cmd_addr`.
- INCR: beat n (n≥1) = (addr aligned down to bytes) + n·bytes, modulo 2^ADDRESS_WIDTH.
- WRAP: total = bytes·(len+1); lower = addr with low log2(total) bits cleared. Next = cur + bytes; if next == lower + total, next = lower.
- Error conditions, all latched at accept:
  - burst RESERVED;
  - WRAP with len not in {1,3,7,15};
  - WRAP with unaligned addr;
  - FIXED with len>15;
  - size > log2(DATA_WIDTH/8).
- An error burst still emits len+1 beats. `beat_addr` holds `cmd_addr` for all of them and `beat_err`=1 on every beat.
- `beat_idx` increments on each beat handshake. `beat_last` = (beat_idx == len).

## Timing
- Reset values: `beat_valid`=0, `beat_addr`=0, `beat_idx`=0, `beat_last`=0, `beat_err`=0, `busy`=0. `cmd_ready`=0 during reset and 1 on the first cycle after.
- All beat outputs are registered. Command handshake in cycle T gives `beat_valid`=1 with beat 0 in T+1.
- Throughput is 1 beat/cycle under continuous `beat_ready`.
- Last-beat handshake in cycle T: `beat_valid`=0 and `cmd_ready`=1 in T+1, so there is one idle cycle between bursts.
- While `beat_valid` && !`beat_ready`, every beat output holds stable.
- `cmd_ready`=0 throughout BURST. A command offered then waits.
- Reset mid-burst: all outputs take reset values in the next cycle and the remaining beats are discarded.
- len=0: a single beat with `beat_last`=1 in T+1.

## Configuration
- `AXI4_4KB_BOUNDARY_CHECK_EN` defined: an INCR burst whose last byte (aligned start + total − 1) lies in a different 4 KB page from the start address sets `beat_err` for the whole burst, with addresses held at `cmd_addr`.
- Undefined: no page check. INCR addresses continue across the page and wrap modulo 2^ADDRESS_WIDTH.

## Test plan
- INCR, addr 0x100, len 3, size 2: beats 0x100, 0x104, 0x108, 0x10C; `beat_last` only on 0x10C; `beat_err`=0.
- WRAP, addr 0x10C, len 3, size 2: beats 0x10C, 0x100, 0x104, 0x108.
- INCR unaligned, addr 0x101, len 1, size 2: beats 0x101 then 0x104. FIXED, addr 0x40, len 2: 0x40 three times.
- RESERVED burst with len 1, or WRAP with len 2: two or three beats at `cmd_addr`, `beat_err`=1 on each.
- INCR, addr 0xFF8, len 3, size 2:
  - with `AXI4_4KB_BOUNDARY_CHECK_EN`: `beat_err`=1 on all four beats;
  - without it: beats 0xFF8, 0xFFC, 0x1000, 0x1004.
- `beat_ready` low for 3 cycles on beat 1 of an INCR burst: outputs stable; no beat lost or duplicated. `areset` pulsed on beat 2: outputs reach reset values the next cycle, then `cmd_ready`=1.

Source files
------------

// File: rtl/axi4_burst_addr_gen_if.sv
// Command and beat channels of the AXI4 burst address generator.
// The generator sits on the slave side; the command source and beat consumer sit on the master side.
interface axi4_burst_addr_gen_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDRESS_WIDTH-1:0] cmd_addr;
    logic [7:0]               cmd_len;
    logic [2:0]               cmd_size;
    logic [1:0]               cmd_burst;
    logic                     beat_valid;
    logic                     beat_ready;
    logic [ADDRESS_WIDTH-1:0] beat_addr;
    logic [7:0]               beat_idx;
    logic                     beat_last;
    logic                     beat_err;
    logic                     busy;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        output cmd_ready, beat_valid, beat_addr, beat_idx, beat_last,
        output beat_err, busy
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, beat_ready,
        input  cmd_ready, beat_valid, beat_addr, beat_idx, beat_last,
        input  beat_err, busy
    );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat address generator for AXI4 FIXED/INCR/WRAP bursts.
// Define AXI4_4KB_BOUNDARY_CHECK_EN to flag INCR bursts that cross a 4 KB page.
module axi4_burst_addr_gen #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    axi4_burst_addr_gen_if.slave bus
);
    localparam int AW = ADDRESS_WIDTH;
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } axburst_e;

    typedef enum logic {IDLE, BURST} state_e;

    state_e   state_q, state_d;
    axburst_e burst_q, burst_d;
    logic [AW-1:0] bytes_q, bytes_d;
    logic [AW-1:0] wrap_lo_q, wrap_lo_d;
    logic [AW-1:0] wrap_hi_q, wrap_hi_d;
    logic [AW-1:0] beat_addr_q, beat_addr_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    beat_idx_q, beat_idx_d;
    logic          beat_valid_q, beat_valid_d;
    logic          beat_last_q, beat_last_d;
    logic          beat_err_q, beat_err_d;
    logic          busy_q, busy_d;

    axburst_e      cmd_burst;
    logic [AW-1:0] cmd_bytes;
    logic [AW-1:0] cmd_total;
    logic [AW-1:0] cmd_lo;
    logic [AW-1:0] cmd_align;
    logic          cmd_err;
    logic [AW-1:0] next_addr;
`ifdef AXI4_4KB_BOUNDARY_CHECK_EN
    logic [AW-1:0] cmd_end;
`endif

    always_comb begin
        cmd_burst = axburst_e'(bus.cmd_burst);
        cmd_bytes = AW'(1) << bus.cmd_size;
        cmd_total = cmd_bytes * AW'(bus.cmd_len) + cmd_bytes;
        cmd_lo    = bus.cmd_addr & ~(cmd_total - AW'(1));
        cmd_align = bus.cmd_addr & ~(cmd_bytes - AW'(1));
        cmd_err   = (cmd_burst == RSVD)
                  | ((cmd_burst == WRAP)
                     & !(bus.cmd_len inside {8'd1, 8'd3, 8'd7, 8'd15}))
                  | ((cmd_burst == WRAP) & (cmd_align != bus.cmd_addr))
                  | ((cmd_burst == FIXED) & (bus.cmd_len > 8'd15))
                  | (bus.cmd_size > MAX_SIZE);
`ifdef AXI4_4KB_BOUNDARY_CHECK_EN
        cmd_end   = cmd_align + cmd_total - AW'(1);
        cmd_err   = cmd_err
                  | ((cmd_burst == INCR)
                     & (cmd_end[AW-1:12] != bus.cmd_addr[AW-1:12]));
`endif
    end

    // Error bursts park on the start address for every beat.
    always_comb begin
        next_addr = beat_addr_q;
        if (!beat_err_q) begin
            unique case (burst_q)
                INCR: next_addr = (beat_addr_q & ~(bytes_q - AW'(1))) + bytes_q;
                WRAP: begin
                    next_addr = beat_addr_q + bytes_q;
                    if (next_addr == wrap_hi_q) next_addr = wrap_lo_q;
                end
                default: next_addr = beat_addr_q;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        bytes_d      = bytes_q;
        wrap_lo_d    = wrap_lo_q;
        wrap_hi_d    = wrap_hi_q;
        len_d        = len_q;
        beat_addr_d  = beat_addr_q;
        beat_idx_d   = beat_idx_q;
        beat_valid_d = beat_valid_q;
        beat_last_d  = beat_last_q;
        beat_err_d   = beat_err_q;
        busy_d       = busy_q;
        unique case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d      = BURST;
                    burst_d      = cmd_burst;
                    bytes_d      = cmd_bytes;
                    wrap_lo_d    = cmd_lo;
                    wrap_hi_d    = cmd_lo + cmd_total;
                    len_d        = bus.cmd_len;
                    beat_addr_d  = bus.cmd_addr;
                    beat_idx_d   = 8'd0;
                    beat_valid_d = 1'b1;
                    beat_last_d  = (bus.cmd_len == 8'd0);
                    beat_err_d   = cmd_err;
                    busy_d       = 1'b1;
                end
            end
            BURST: begin
                if (bus.beat_ready) begin
                    if (beat_last_q) begin
                        state_d      = IDLE;
                        beat_valid_d = 1'b0;
                        beat_last_d  = 1'b0;
                        busy_d       = 1'b0;
                    end else begin
                        beat_addr_d = next_addr;
                        beat_idx_d  = beat_idx_q + 8'd1;
                        beat_last_d = ((beat_idx_q + 8'd1) == len_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            burst_q      <= FIXED;
            bytes_q      <= '0;
            wrap_lo_q    <= '0;
            wrap_hi_q    <= '0;
            len_q        <= '0;
            beat_addr_q  <= '0;
            beat_idx_q   <= '0;
            beat_valid_q <= 1'b0;
            beat_last_q  <= 1'b0;
            beat_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            burst_q      <= burst_d;
            bytes_q      <= bytes_d;
            wrap_lo_q    <= wrap_lo_d;
            wrap_hi_q    <= wrap_hi_d;
            len_q        <= len_d;
            beat_addr_q  <= beat_addr_d;
            beat_idx_q   <= beat_idx_d;
            beat_valid_q <= beat_valid_d;
            beat_last_q  <= beat_last_d;
            beat_err_q   <= beat_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.cmd_ready  = (state_q == IDLE) && !areset;
    assign bus.beat_valid = beat_valid_q;
    assign bus.beat_addr  = beat_addr_q;
    assign bus.beat_idx   = beat_idx_q;
    assign bus.beat_last  = beat_last_q;
    assign bus.beat_err   = beat_err_q;
    assign bus.busy       = busy_q;
endmodule
